// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder slice (two half adders + OR) walks WIDTH bits LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r;
    logic             s1, c1, s, c2, c;
    logic             last;

    half_adder u_ha0 (.x(a_sr[0]), .y(b_sr[0]), .s(s1), .c(c1));
    half_adder u_ha1 (.x(s1),      .y(carry),   .s(s),  .c(c2));

    assign c    = c1 | c2;
    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: capture on accepted start, then shift one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_r <= {s, sum_r[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= c;
            cnt   <= cnt + 1'b1;
            if (last) cout_r <= c;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // On the MSB step the slice inputs are the sign bits of both operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (state == RUN && last)
            ovf_r <= (a_sr[0] == b_sr[0]) & (s != a_sr[0]);
    end

    assign ovf = ovf_r;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_r;
    assign cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: timeline/arithmetic reference model plus directed literal checks.
// Define SERIAL_ADD_OVF_EN for both files to exercise the ovf output.

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int passed = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase 0 = idle, 1..WIDTH = bit cycles, WIDTH+1 = result cycle.
    int               phase = 0;
    logic [WIDTH:0]   pend_res = '0;
    logic             pend_ovf = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf = 1'b0;

    function automatic logic signed_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int r;
        r = int'($signed(x)) + int'($signed(y));
        return (r > (2 ** (WIDTH - 1)) - 1) || (r < -(2 ** (WIDTH - 1)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (phase == 0) begin
            if (start) begin
                phase    <= 1;
                pend_res <= {1'b0, a} + {1'b0, b};
                pend_ovf <= signed_ovf(a, b);
            end
        end else if (phase == WIDTH) begin
            phase  <= WIDTH + 1;
            m_sum  <= pend_res[WIDTH-1:0];
            m_cout <= pend_res[WIDTH];
            m_ovf  <= pend_ovf;
        end else if (phase == WIDTH + 1) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
        end
    end

    // Every cycle: handshake timing always; result outputs whenever they are not mid-shift.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(phase >= 1 && phase <= WIDTH));
        check("done", 32'(done), 32'(phase == WIDTH + 1));
        if (phase == 0 || phase == WIDTH + 1) begin
            check("sum_model", 32'(sum), 32'(m_sum));
            check("cout_model", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
            check("ovf_model", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the negedge right after the accepting edge; done must appear WIDTH negedges later.
    task automatic wait_done(input string name, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int n;
        n = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            @(negedge clk);
            if (done) begin n = i; break; end
        end
        check({name, "_latency"}, 32'(n), 32'(WIDTH));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADD_OVF_EN
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;

        // Reset state held while clock runs
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_done", 32'(done), 32'd0);

        // Basic add, result held afterwards
        start_op(8'h5A, 8'h25);
        check("t2_busy", 32'(busy), 32'd1);
        wait_done("t2", 8'h7F, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("t2_hold_sum", 32'(sum), 32'h7F);
        check("t2_hold_cout", 32'(cout), 32'd0);

        // Carry out, then carry cleared between operations
        start_op(8'hFF, 8'h01);
        wait_done("t3a", 8'h00, 1'b1, 1'b0);
        start_op(8'h00, 8'h00);
        wait_done("t3b", 8'h00, 1'b0, 1'b0);

        // start held high through RUN/DONE with new operands
        @(negedge clk);
        a = 8'h5A; b = 8'h25; start = 1'b1;
        @(negedge clk);
        a = 8'h11; b = 8'h22;
        wait_done("t4a", 8'h7F, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_idle_gap", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("t4_reaccept", 32'(busy), 32'd1);
        wait_done("t4b", 8'h33, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-operation
        start_op(8'hF0, 8'h0F);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_sum", 32'(sum), 32'd0);
        check("t5_rst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        check("t5_no_done", 32'(done), 32'd0);
        start_op(8'h03, 8'h04);
        wait_done("t5", 8'h07, 1'b0, 1'b0);

        // Signed overflow cases
        start_op(8'h7F, 8'h01);
        wait_done("t6a", 8'h80, 1'b0, 1'b1);
        start_op(8'hFF, 8'hFF);
        wait_done("t6b", 8'hFE, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
